lbuff_ret_ctrl: RTL and testbench

- Per-entry status tracker for the 32-entry load buffer; sits directly downstream of the dispatch load-ID allocator.
- Consumes the allocated lbuff IDs and ROB load commits, and tracks each entry through ALLOC, DONE and CMT.
- Produces the in-order, up-to-4-wide release vector that the allocator uses as its return/free input.
- Handles mispredict rollback and trap flush.

---
 rtl/lbuff_ret_ctrl_pkg.sv | 27 ++
 rtl/lbuff_ret_ctrl_sel.sv | 26 ++
 rtl/lbuff_ret_ctrl.sv | 173 +++++++++++++++++
 tb/tb_lbuff_ret_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lbuff_ret_ctrl_pkg.sv
// Shared types and constants for the load buffer retire controller.
// Entry state encodings, pointer types and a 4-bit popcount helper.
package lbuff_ret_ctrl_pkg;

  localparam int ENTRIES  = 32;
  localparam int ID_WIDTH = 5;
  localparam int WIDTH    = 4;
  localparam int PTR_W    = ID_WIDTH + 1;

  typedef enum logic [1:0] {
    LB_FREE  = 2'd0,
    LB_ALLOC = 2'd1,
    LB_DONE  = 2'd2,
    LB_CMT   = 2'd3
  } lb_state_e;

  typedef logic [ID_WIDTH-1:0] lb_id_t;
  typedef logic [PTR_W-1:0]    lb_ptr_t;

  function automatic logic [2:0] popcount4(
    input logic [3:0] v
  );
    return {2'b0, v[0]} + {2'b0, v[1]}
         + {2'b0, v[2]} + {2'b0, v[3]};
  endfunction

endpackage

// File: rtl/lbuff_ret_ctrl_sel.sv
// 4-wide in-order release selector.
// Emits a thermometer of committed entries starting at head.
module lbuff_ret_sel
  import lbuff_ret_ctrl_pkg::*;
(
  input  lb_id_t                    i_head_idx,
  input  logic [ENTRIES-1:0][1:0]   i_st,
  input  lb_ptr_t                   i_dist,
  output logic [WIDTH-1:0]          o_ret
);

  // Walk head..head+3; stop at first non-CMT or at cmt
  always_comb begin : sel
    logic   run;
    lb_id_t idx;
    o_ret = '0;
    run   = 1'b1;
    idx   = '0;
    for (int k = 0; k < WIDTH; k++) begin
      idx      = i_head_idx + lb_id_t'(k);
      run      = run && (i_st[idx] == LB_CMT);
      o_ret[k] = run && (lb_ptr_t'(k) < i_dist);
    end
  end

endmodule

// File: rtl/lbuff_ret_ctrl.sv
// Load buffer per-entry status tracker and in-order release.
// Optional retired-load counter: define LBUFF_RET_PERF_EN.
module lbuff_ret_ctrl
  import lbuff_ret_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    i_alloc_vld,
  input  logic [ID_WIDTH-1:0] i_alloc_id_0,
  input  logic [ID_WIDTH-1:0] i_alloc_id_1,
  input  logic [ID_WIDTH-1:0] i_alloc_id_2,
  input  logic [ID_WIDTH-1:0] i_alloc_id_3,
  input  logic [1:0]          i_wb_vld,
  input  logic [ID_WIDTH-1:0] i_wb_id_0,
  input  logic [ID_WIDTH-1:0] i_wb_id_1,
  input  logic [2:0]          i_cmt_nums,
  input  logic                i_mis_flush,
  input  logic [ID_WIDTH-1:0] i_mis_ld_id,
  input  logic                i_trap_flush,
  output logic [WIDTH-1:0]    o_ret_vld,
  output logic [ID_WIDTH-1:0] o_head_id,
  output logic [ID_WIDTH-1:0] o_cmt_id,
  output logic [ID_WIDTH:0]   o_busy_cnt,
  output logic [31:0]         o_perf_ret_cnt
);

  logic [ENTRIES-1:0][1:0] st_q, st_d;
  lb_ptr_t head_q, head_d;
  lb_ptr_t cmt_q, cmt_d;
  lb_ptr_t tail_q, tail_d;

  logic [WIDTH-1:0][ID_WIDTH-1:0] alloc_id;
  logic [1:0][ID_WIDTH-1:0]       wb_id;
  logic [WIDTH-1:0]               ret_raw;
  logic [ENTRIES-1:0]             rel_mask;
  lb_id_t  head_idx, cmt_idx, mis_off;
  lb_ptr_t mis_tail, flush_n;

  assign alloc_id = {i_alloc_id_3, i_alloc_id_2,
                     i_alloc_id_1, i_alloc_id_0};
  assign wb_id    = {i_wb_id_1, i_wb_id_0};
  assign head_idx = head_q[ID_WIDTH-1:0];
  assign cmt_idx  = cmt_q[ID_WIDTH-1:0];

  // Flush point sits at or past cmt; rebuild its wrap bit from cmt
  assign mis_off  = i_mis_ld_id - cmt_idx;
  assign mis_tail = cmt_q + {1'b0, mis_off};
  assign flush_n  = tail_q - mis_tail;

  lbuff_ret_sel u_sel (
    .i_head_idx (head_idx),
    .i_st       (st_q),
    .i_dist     (cmt_q - head_q),
    .o_ret      (ret_raw)
  );

  assign o_ret_vld  = i_trap_flush ? '0 : ret_raw;
  assign o_head_id  = head_idx;
  assign o_cmt_id   = cmt_idx;
  assign o_busy_cnt = tail_q - head_q;

  // Entries freed by this cycle's release
  always_comb begin : rel
    rel_mask = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (ret_raw[k])
        rel_mask[head_idx + lb_id_t'(k)] = 1'b1;
    end
  end

  // Next entry states and pointers
  always_comb begin : nxt
    st_d   = st_q;
    head_d = head_q;
    cmt_d  = cmt_q;
    tail_d = tail_q;
    if (i_trap_flush) begin
      st_d   = '0;
      head_d = '0;
      cmt_d  = '0;
      tail_d = '0;
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        if (ret_raw[k])
          st_d[head_idx + lb_id_t'(k)] = LB_FREE;
      end
      head_d = head_q
             + lb_ptr_t'(popcount4(ret_raw));
      for (int k = 0; k < WIDTH; k++) begin
        if (3'(k) < i_cmt_nums)
          st_d[cmt_idx + lb_id_t'(k)] = LB_CMT;
      end
      cmt_d = cmt_q + lb_ptr_t'(i_cmt_nums);
      if (i_mis_flush) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (lb_ptr_t'(i) < flush_n)
            st_d[i_mis_ld_id + lb_id_t'(i)] = LB_FREE;
        end
        tail_d = mis_tail;
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (i_wb_vld[p] &&
              st_q[wb_id[p]] == LB_ALLOC)
            st_d[wb_id[p]] = LB_DONE;
        end
        for (int k = 0; k < WIDTH; k++) begin
          if (i_alloc_vld[k])
            st_d[alloc_id[k]] = LB_ALLOC;
        end
        tail_d = tail_q
               + lb_ptr_t'(popcount4(i_alloc_vld));
      end
    end
  end

  // State and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= '0;
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
    end else begin
      st_q   <= st_d;
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
    end
  end

`ifdef LBUFF_RET_PERF_EN
  logic [31:0] perf_q, perf_d;
  logic [32:0] perf_sum;

  // Saturating retired-load count
  always_comb begin
    perf_sum = {1'b0, perf_q}
             + 33'(popcount4(o_ret_vld));
    perf_d   = perf_sum[32] ? '1 : perf_sum[31:0];
  end

  // Counter register, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign o_perf_ret_cnt = perf_q;
`else
  assign o_perf_ret_cnt = '0;
`endif

  // Allocator and ROB protocol checks
  always @(posedge clk) begin : proto
    if (!rst && !i_trap_flush) begin
      if (!i_mis_flush) begin
        for (int k = 0; k < WIDTH; k++) begin
          if (i_alloc_vld[k])
            assert (st_q[alloc_id[k]] == LB_FREE ||
                    rel_mask[alloc_id[k]]);
        end
      end
      assert (lb_ptr_t'(i_cmt_nums) <=
              lb_ptr_t'(tail_q - cmt_q));
      for (int k = 0; k < WIDTH; k++) begin
        if (3'(k) < i_cmt_nums)
          assert (st_q[cmt_idx + lb_id_t'(k)]
                  == LB_DONE);
      end
    end
  end

endmodule

// File: tb/tb_lbuff_ret_ctrl.sv
// Directed bench for lbuff_ret_ctrl.
// Vector table for retire flows plus wrap, flush and perf sequences.
module tb_lbuff_ret_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i_alloc_vld;
  logic [4:0] i_alloc_id_0, i_alloc_id_1;
  logic [4:0] i_alloc_id_2, i_alloc_id_3;
  logic [1:0] i_wb_vld;
  logic [4:0] i_wb_id_0, i_wb_id_1;
  logic [2:0] i_cmt_nums;
  logic       i_mis_flush;
  logic [4:0] i_mis_ld_id;
  logic       i_trap_flush;
  logic [3:0] o_ret_vld;
  logic [4:0] o_head_id, o_cmt_id;
  logic [5:0] o_busy_cnt;
  logic [31:0] o_perf_ret_cnt;

`ifdef LBUFF_RET_PERF_EN
  localparam logic [31:0] PERF_EXP = 32'd8;
`else
  localparam logic [31:0] PERF_EXP = 32'd0;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [4:0] tb_tail;

  always #5 clk = ~clk;

  lbuff_ret_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .i_alloc_vld    (i_alloc_vld),
    .i_alloc_id_0   (i_alloc_id_0),
    .i_alloc_id_1   (i_alloc_id_1),
    .i_alloc_id_2   (i_alloc_id_2),
    .i_alloc_id_3   (i_alloc_id_3),
    .i_wb_vld       (i_wb_vld),
    .i_wb_id_0      (i_wb_id_0),
    .i_wb_id_1      (i_wb_id_1),
    .i_cmt_nums     (i_cmt_nums),
    .i_mis_flush    (i_mis_flush),
    .i_mis_ld_id    (i_mis_ld_id),
    .i_trap_flush   (i_trap_flush),
    .o_ret_vld      (o_ret_vld),
    .o_head_id      (o_head_id),
    .o_cmt_id       (o_cmt_id),
    .o_busy_cnt     (o_busy_cnt),
    .o_perf_ret_cnt (o_perf_ret_cnt)
  );

  typedef struct {
    logic [3:0] av;
    logic [4:0] a0;
    logic [1:0] wv;
    logic [4:0] w0;
    logic [4:0] w1;
    logic [2:0] cn;
    logic [3:0] ret;
    logic [4:0] head;
    logic [4:0] cmt;
    logic [5:0] busy;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic clr();
    i_alloc_vld  = '0;
    i_alloc_id_0 = '0;
    i_alloc_id_1 = '0;
    i_alloc_id_2 = '0;
    i_alloc_id_3 = '0;
    i_wb_vld     = '0;
    i_wb_id_0    = '0;
    i_wb_id_1    = '0;
    i_cmt_nums   = '0;
    i_mis_flush  = 1'b0;
    i_mis_ld_id  = '0;
    i_trap_flush = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    clr();
  endtask

  task automatic set_alloc(input logic [3:0] v,
                           input logic [4:0] a0);
    i_alloc_vld  = v;
    i_alloc_id_0 = a0;
    i_alloc_id_1 = a0 + 5'd1;
    i_alloc_id_2 = a0 + 5'd2;
    i_alloc_id_3 = a0 + 5'd3;
  endtask

  task automatic set_wb(input logic [1:0] v,
                        input logic [4:0] w0,
                        input logic [4:0] w1);
    i_wb_vld  = v;
    i_wb_id_0 = w0;
    i_wb_id_1 = w1;
  endtask

  // alloc n, write back, commit, release; pointers advance by n
  task automatic pass(input int n);
    logic [3:0] m;
    m = 4'((1 << n) - 1);
    set_alloc(m, tb_tail);
    tick();
    set_wb((n >= 2) ? 2'b11 : 2'b01,
           tb_tail, tb_tail + 5'd1);
    tick();
    set_wb((n == 4) ? 2'b11 :
           (n == 3) ? 2'b01 : 2'b00,
           tb_tail + 5'd2, tb_tail + 5'd3);
    tick();
    i_cmt_nums = 3'(n);
    tick();
    #1 chk("pass_ret", 32'(o_ret_vld), 32'(m));
    tick();
    tb_tail = tb_tail + 5'(n);
  endtask

  initial begin
    tbl[0]  = '{4'b1111, 5'd0, 2'b00, 5'd0, 5'd0,
                3'd0, 4'b0000, 5'd0, 5'd0, 6'd0};
    tbl[1]  = '{4'b0000, 5'd0, 2'b11, 5'd0, 5'd1,
                3'd0, 4'b0000, 5'd0, 5'd0, 6'd4};
    tbl[2]  = '{4'b0000, 5'd0, 2'b11, 5'd2, 5'd3,
                3'd0, 4'b0000, 5'd0, 5'd0, 6'd4};
    tbl[3]  = '{4'b0000, 5'd0, 2'b00, 5'd0, 5'd0,
                3'd4, 4'b0000, 5'd0, 5'd0, 6'd4};
    tbl[4]  = '{4'b0000, 5'd0, 2'b00, 5'd0, 5'd0,
                3'd0, 4'b1111, 5'd0, 5'd4, 6'd4};
    tbl[5]  = '{4'b0111, 5'd4, 2'b00, 5'd0, 5'd0,
                3'd0, 4'b0000, 5'd4, 5'd4, 6'd0};
    tbl[6]  = '{4'b0000, 5'd0, 2'b11, 5'd4, 5'd5,
                3'd0, 4'b0000, 5'd4, 5'd4, 6'd3};
    tbl[7]  = '{4'b0000, 5'd0, 2'b01, 5'd6, 5'd0,
                3'd0, 4'b0000, 5'd4, 5'd4, 6'd3};
    tbl[8]  = '{4'b0000, 5'd0, 2'b00, 5'd0, 5'd0,
                3'd2, 4'b0000, 5'd4, 5'd4, 6'd3};
    tbl[9]  = '{4'b0000, 5'd0, 2'b00, 5'd0, 5'd0,
                3'd0, 4'b0011, 5'd4, 5'd6, 6'd3};
    tbl[10] = '{4'b0000, 5'd0, 2'b00, 5'd0, 5'd0,
                3'd1, 4'b0000, 5'd6, 5'd6, 6'd1};
    tbl[11] = '{4'b0000, 5'd0, 2'b00, 5'd0, 5'd0,
                3'd0, 4'b0001, 5'd6, 5'd7, 6'd1};
    tbl[12] = '{4'b0000, 5'd0, 2'b00, 5'd0, 5'd0,
                3'd0, 4'b0000, 5'd7, 5'd7, 6'd0};

    rst = 1'b1;
    clr();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_perf", o_perf_ret_cnt, 32'd0);

    // basic retire and partial commit
    for (int i = 0; i < 13; i++) begin
      set_alloc(tbl[i].av, tbl[i].a0);
      set_wb(tbl[i].wv, tbl[i].w0, tbl[i].w1);
      i_cmt_nums = tbl[i].cn;
      #1;
      chk($sformatf("v%0d_ret", i),
          32'(o_ret_vld), 32'(tbl[i].ret));
      chk($sformatf("v%0d_head", i),
          32'(o_head_id), 32'(tbl[i].head));
      chk($sformatf("v%0d_cmt", i),
          32'(o_cmt_id), 32'(tbl[i].cmt));
      chk($sformatf("v%0d_busy", i),
          32'(o_busy_cnt), 32'(tbl[i].busy));
      tick();
    end
    tb_tail = 5'd7;

    // walk head to 30, then fill all 32 entries
    for (int i = 0; i < 5; i++) pass(4);
    pass(3);
    #1 chk("walk_head", 32'(o_head_id), 32'd30);
    for (int i = 0; i < 8; i++) begin
      set_alloc(4'b1111, tb_tail);
      tick();
      tb_tail = tb_tail + 5'd4;
    end
    #1 chk("full_busy", 32'(o_busy_cnt), 32'd32);
    chk("full_head", 32'(o_head_id), 32'd30);
    set_wb(2'b11, 5'd30, 5'd31);
    tick();
    set_wb(2'b11, 5'd0, 5'd1);
    tick();
    i_cmt_nums = 3'd4;
    tick();
    #1 chk("wrap_ret", 32'(o_ret_vld), 32'hF);
    tick();
    #1 chk("wrap_head", 32'(o_head_id), 32'd2);
    chk("wrap_busy", 32'(o_busy_cnt), 32'd28);

    // trap flush with commit, alloc and release pending
    set_wb(2'b11, 5'd2, 5'd3);
    tick();
    set_wb(2'b11, 5'd4, 5'd5);
    tick();
    i_cmt_nums = 3'd2;
    tick();
    i_cmt_nums = 3'd2;
    set_alloc(4'b1111, 5'd30);
    #1 chk("pre_trap_ret", 32'(o_ret_vld), 32'h3);
    i_trap_flush = 1'b1;
    #1 chk("trap_ret", 32'(o_ret_vld), 32'h0);
    tick();
    #1 chk("trap_head", 32'(o_head_id), 32'd0);
    chk("trap_cmt", 32'(o_cmt_id), 32'd0);
    chk("trap_busy", 32'(o_busy_cnt), 32'd0);
    chk("trap_ret1", 32'(o_ret_vld), 32'h0);
    tb_tail = 5'd0;

    // mispredict: live 5..12, cmt 7, flush at 9
    pass(4);
    pass(1);
    set_alloc(4'b1111, 5'd5);
    tick();
    set_alloc(4'b1111, 5'd9);
    tick();
    set_wb(2'b11, 5'd5, 5'd6);
    tick();
    i_cmt_nums = 3'd2;
    tick();
    i_mis_flush = 1'b1;
    i_mis_ld_id = 5'd9;
    set_alloc(4'b1111, 5'd13);
    #1 chk("mis_ret", 32'(o_ret_vld), 32'h3);
    chk("mis_pre_busy", 32'(o_busy_cnt), 32'd8);
    tick();
    #1 chk("mis_head", 32'(o_head_id), 32'd7);
    chk("mis_cmt", 32'(o_cmt_id), 32'd7);
    chk("mis_busy", 32'(o_busy_cnt), 32'd2);
    set_wb(2'b01, 5'd10, 5'd0);
    tick();
    set_alloc(4'b0011, 5'd9);
    tick();
    #1 chk("mis_realloc", 32'(o_busy_cnt), 32'd4);
    set_wb(2'b11, 5'd7, 5'd8);
    tick();
    set_wb(2'b11, 5'd9, 5'd10);
    tick();
    i_cmt_nums = 3'd4;
    tick();
    #1 chk("mis_ret4", 32'(o_ret_vld), 32'hF);
    tick();
    #1 chk("mis_end_head", 32'(o_head_id), 32'd11);
    chk("mis_end_busy", 32'(o_busy_cnt), 32'd0);

    // perf: retire 4, 3, 1 on consecutive cycles
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("perf_rst", o_perf_ret_cnt, 32'd0);
    set_alloc(4'b1111, 5'd0);
    tick();
    set_alloc(4'b1111, 5'd4);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_wb(2'b11, 5'(2 * i), 5'(2 * i + 1));
      tick();
    end
    i_cmt_nums = 3'd4;
    tick();
    i_cmt_nums = 3'd3;
    #1 chk("perf_ret4", 32'(o_ret_vld), 32'hF);
    tick();
    i_cmt_nums = 3'd1;
    #1 chk("perf_ret3", 32'(o_ret_vld), 32'h7);
    tick();
    #1 chk("perf_ret1", 32'(o_ret_vld), 32'h1);
    tick();
    #1 chk("perf_cnt", o_perf_ret_cnt, PERF_EXP);
    i_trap_flush = 1'b1;
    tick();
    #1 chk("perf_trap", o_perf_ret_cnt, PERF_EXP);
    chk("perf_busy", 32'(o_busy_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
